// File: rtl/eq_pkg.sv
// eq_pkg: shared types, config selectors and arithmetic helpers for the TDM equalizer
package eq_pkg;
   typedef enum logic [2:0] {IDLE, MAC, BAND, FINAL, OUT} state_t;
   localparam logic CFG_COEF = 1'b0;
   localparam logic CFG_GAIN = 1'b1;
   function automatic int acc_w(input int dw, input int cw, input int nt);
      return dw + cw + $clog2(nt);
   endfunction
   function automatic int sum_w(input int dw, input int gw, input int nb);
      return dw + gw + $clog2(nb);
   endfunction
   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
   function automatic int max_w(input int a, input int b);
      return a > b ? a : b;
   endfunction
   // clamps v to the signed range of a w-bit value; caller truncates to w bits
   function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      return v > hi ? hi : v < lo ? lo : v;
   endfunction
endpackage

// File: rtl/eq_mac.sv
// eq_mac: signed multiplier feeding an accumulator with synchronous clear and enable
module eq_mac #(
   parameter int A_W   = 16,
   parameter int B_W   = 16,
   parameter int ACC_W = 36
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_clr,
   input  logic                    i_en,
   input  logic signed [A_W-1:0]   i_a,
   input  logic signed [B_W-1:0]   i_b,
   output logic signed [ACC_W-1:0] o_acc
);
   logic signed [A_W+B_W-1:0] w_prod;
   assign w_prod = i_a * i_b;
   always_ff @(posedge i_clk)
      if (!i_rst_n || i_clr) o_acc <= '0;
      else if (i_en) o_acc <= o_acc + ACC_W'(w_prod);
endmodule

// File: rtl/eq_nband_tdm.sv
// eq_nband_tdm: N-band FIR equalizer, one shared tap multiplier, programmable coefs and gains
module eq_nband_tdm
   import eq_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 16,
   parameter int GAIN_W    = 8,
   parameter int GAIN_FRAC = 4,
   parameter int NUM_BANDS = 8,
   parameter int NUM_TAPS  = 15
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic                                  i_in_valid,
   output logic                                  o_in_ready,
   input  logic [DATA_W-1:0]                     i_in_data,
   output logic                                  o_out_valid,
   input  logic                                  i_out_ready,
   output logic [DATA_W-1:0]                     o_out_data,
   input  logic                                  i_cfg_we,
   input  logic                                  i_cfg_sel,
   input  logic [idx_w(NUM_BANDS)-1:0]           i_cfg_band,
   input  logic [idx_w(NUM_TAPS)-1:0]            i_cfg_tap,
   input  logic [max_w(COEF_W, GAIN_W)-1:0]      i_cfg_data,
   output logic                                  o_cfg_busy
);
   localparam int ACC_W = acc_w(DATA_W, COEF_W, NUM_TAPS);
   localparam int SUM_W = sum_w(DATA_W, GAIN_W, NUM_BANDS);
   localparam int BW    = idx_w(NUM_BANDS);
   localparam int TW    = idx_w(NUM_TAPS);

   state_t                     r_state;
   logic [BW-1:0]              r_band;
   logic [TW-1:0]              r_tap;
   logic signed [DATA_W-1:0]   r_d [NUM_TAPS];
   logic signed [COEF_W-1:0]   r_coef [NUM_BANDS][NUM_TAPS];
   logic signed [GAIN_W-1:0]   r_gain [NUM_BANDS];
   logic signed [SUM_W-1:0]    r_sum;
   logic signed [DATA_W-1:0]   r_out;
   logic                       r_out_valid;

   logic signed [ACC_W-1:0]         w_acc;
   logic signed [DATA_W-1:0]        w_band;
   logic signed [DATA_W+GAIN_W-1:0] w_bg;
   logic signed [DATA_W-1:0]        w_fin;

   eq_mac #(.A_W(DATA_W), .B_W(COEF_W), .ACC_W(ACC_W)) u_mac (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (r_state == IDLE || r_state == BAND),
      .i_en    (r_state == MAC),
      .i_a     (r_d[r_tap]),
      .i_b     (r_coef[r_band][r_tap]),
      .o_acc   (w_acc)
   );

   assign w_band = DATA_W'(sat(64'(w_acc >>> (COEF_W - 1)), DATA_W));
   assign w_bg   = w_band * r_gain[r_band];
   assign w_fin  = DATA_W'(sat(64'(r_sum >>> GAIN_FRAC), DATA_W));

   assign o_in_ready  = r_state == IDLE;
   assign o_cfg_busy  = r_state != IDLE;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_band      <= '0;
         r_tap       <= '0;
         r_sum       <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         for (int k = 0; k < NUM_TAPS; k++) r_d[k] <= '0;
         for (int b = 0; b < NUM_BANDS; b++) begin
            r_gain[b] <= GAIN_W'(1 << GAIN_FRAC);
            for (int t = 0; t < NUM_TAPS; t++) r_coef[b][t] <= '0;
         end
      end else begin
         // writes land on the accept edge too, so the new value serves that sample
         if (i_cfg_we && r_state == IDLE && int'(i_cfg_band) < NUM_BANDS) begin
            if (i_cfg_sel == CFG_GAIN) r_gain[i_cfg_band] <= i_cfg_data[GAIN_W-1:0];
            else if (int'(i_cfg_tap) < NUM_TAPS) r_coef[i_cfg_band][i_cfg_tap] <= i_cfg_data[COEF_W-1:0];
         end
         case (r_state)
            IDLE:
               if (i_in_valid) begin
                  r_d[0] <= i_in_data;
                  for (int k = 1; k < NUM_TAPS; k++) r_d[k] <= r_d[k-1];
                  r_sum   <= '0;
                  r_band  <= '0;
                  r_tap   <= '0;
                  r_state <= MAC;
               end
            MAC: begin
               r_tap <= r_tap + 1'b1;
               if (r_tap == TW'(NUM_TAPS - 1)) begin
                  r_tap   <= '0;
                  r_state <= BAND;
               end
            end
            BAND: begin
               r_sum <= r_sum + SUM_W'(w_bg);
               if (r_band == BW'(NUM_BANDS - 1)) r_state <= FINAL;
               else begin
                  r_band  <= r_band + 1'b1;
                  r_state <= MAC;
               end
            end
            FINAL: begin
               r_out       <= w_fin;
               r_out_valid <= 1'b1;
               r_state     <= OUT;
            end
            OUT:
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_eq_nband_tdm.sv
// tb_eq_nband_tdm: scoreboard bench for eq_nband_tdm with default parameters
module tb_eq_nband_tdm;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        cfg_we = 1'b0;
   logic        cfg_sel = 1'b0;
   logic [2:0]  cfg_band = '0;
   logic [3:0]  cfg_tap = '0;
   logic [15:0] cfg_data = '0;
   logic        cfg_busy;

   int     n_cmp = 0;
   int     n_bad = 0;
   int     cyc = 0;
   int     t0 = 0;
   longint q[$];
   int     m_coef [8][15];
   int     m_gain [8];
   int     m_d [15];

   eq_nband_tdm dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
      .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel), .i_cfg_band(cfg_band),
      .i_cfg_tap(cfg_tap), .i_cfg_data(cfg_data), .o_cfg_busy(cfg_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint sat16(input longint v);
      return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
   endfunction

   function automatic longint mdl_out();
      longint s = 0;
      for (int b = 0; b < 8; b++) begin
         longint a = 0;
         for (int t = 0; t < 15; t++) a += longint'(m_d[t]) * longint'(m_coef[b][t]);
         s += sat16(a >>> 15) * longint'(m_gain[b]);
      end
      return sat16(s >>> 4);
   endfunction

   task automatic mdl_reset();
      for (int b = 0; b < 8; b++) begin
         m_gain[b] = 16;
         for (int t = 0; t < 15; t++) m_coef[b][t] = 0;
      end
      for (int t = 0; t < 15; t++) m_d[t] = 0;
   endtask

   task automatic rst();
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      mdl_reset();
   endtask

   task automatic cfg_raw(input bit sel, input int band, input int tap, input int data);
      @(negedge clk);
      cfg_we = 1'b1;
      cfg_sel = sel;
      cfg_band = 3'(band);
      cfg_tap = 4'(tap);
      cfg_data = 16'(data);
      @(negedge clk) cfg_we = 1'b0;
   endtask

   task automatic cfg(input bit sel, input int band, input int tap, input int data);
      cfg_raw(sel, band, tap, data);
      if (sel) m_gain[band] = int'($signed(cfg_data[7:0]));
      else if (tap < 15) m_coef[band][tap] = int'($signed(cfg_data));
   endtask

   task automatic send(input int x, input bit push, input bit use_mdl, input longint exp);
      @(negedge clk);
      check("in_ready_pre", longint'(in_ready), 1);
      in_valid = 1'b1;
      in_data = 16'(x);
      for (int t = 14; t > 0; t--) m_d[t] = m_d[t-1];
      m_d[0] = int'($signed(in_data));
      if (push) q.push_back(use_mdl ? mdl_out() : exp);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      t0 = cyc;
   endtask

   task automatic recv(input int hold);
      int n = 0;
      while (!out_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) begin
         check("out_timeout", 0, 1);
         return;
      end
      check("latency", longint'(cyc - t0), 129);
      if (q.size() == 0) check("sb_empty", 1, 0);
      else check("out_data", longint'($signed(out_data)), q.pop_front());
      if (hold > 0) begin
         int bad = 0;
         logic [15:0] d = out_data;
         repeat (hold) begin
            @(negedge clk);
            if (out_data != d || !out_valid || in_ready) bad++;
         end
         check("bp_hold", longint'(bad), 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("ov_after_hs", longint'(out_valid), 0);
      check("in_ready_after_hs", longint'(in_ready), 1);
   endtask

   initial begin
      mdl_reset();
      rst();
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_in_ready", longint'(in_ready), 1);
      check("rst_cfg_busy", longint'(cfg_busy), 0);
      check("rst_out_data", longint'(out_data), 0);
      // impulse response through band 0
      cfg(0, 0, 0, 16384);
      cfg(0, 0, 2, -8192);
      send(20000, 1, 0, 10000); recv(0);
      send(0, 1, 0, 0);         recv(0);
      send(0, 1, 0, -5000);     recv(0);
      // saturation both directions
      rst();
      cfg(0, 0, 0, 32767);
      cfg(0, 1, 0, 32767);
      send(30000, 1, 0, 32767);   recv(0);
      send(-30000, 1, 0, -32768); recv(0);
      // gain scaling, then backpressure
      rst();
      cfg(0, 0, 0, 16384);
      cfg(0, 0, 2, -8192);
      cfg(1, 0, 0, 8);
      send(20000, 1, 0, 5000);   recv(0);
      cfg(1, 0, 0, -16);
      send(20000, 1, 0, -10000); recv(0);
      send(0, 1, 1, 0);          recv(50);
      // config writes dropped while busy
      rst();
      cfg(0, 0, 0, 16384);
      cfg(0, 0, 2, -8192);
      send(20000, 1, 0, 10000);
      check("cfg_busy_mac", longint'(cfg_busy), 1);
      cfg_raw(0, 0, 0, 0);
      recv(0);
      cfg(0, 0, 0, 0);
      send(20000, 1, 0, 0); recv(0);
      // reset during BAND of band 3
      cfg(1, 0, 0, 80);
      cfg(0, 0, 0, 16384);
      send(20000, 0, 0, 0);
      repeat (63) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", longint'(out_valid), 0);
      check("midrst_in_ready", longint'(in_ready), 1);
      check("midrst_cfg_busy", longint'(cfg_busy), 0);
      rst_n = 1'b1;
      mdl_reset();
      send(20000, 1, 0, 0); recv(0);
      cfg(0, 0, 0, 16384);
      send(20000, 1, 0, 10000); recv(0);
      // random programming with out-of-range taps, checked against the model
      rst();
      for (int i = 0; i < 16; i++)
         cfg(0, int'($urandom_range(7)), int'($urandom_range(15)), int'($urandom_range(65535)) - 32768);
      for (int b = 0; b < 8; b++) cfg(1, b, 0, int'($urandom_range(255)) - 128);
      for (int i = 0; i < 5; i++) begin
         send(int'($urandom_range(65535)) - 32768, 1, 1, 0);
         recv(0);
      end
      check("sb_left", longint'(q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/eq_nband_tdm.md
Name: eq_nband_tdm

Overview:
- Parametrised successor to the fixed 8-band equalizer: N-band FIR equalizer sharing one multiplier across all bands and taps (time-division multiplexing).
- Coefficients and per-band gains are run-time programmable through a config port. No hard-wired taps.
- Sits between the audio sample source and the output DAC path. Valid/ready handshake on both sample sides.

Parameters:
- DATA_W, 16, sample width, signed Q1.(DATA_W-1).
- COEF_W, 16, coefficient width, signed Q1.(COEF_W-1).
- GAIN_W, 8, gain width, signed Q(GAIN_W-GAIN_FRAC).GAIN_FRAC.
- GAIN_FRAC, 4, gain fractional bits; unity gain = 1<<GAIN_FRAC.
- NUM_BANDS, 8, number of bands (>=1).
- NUM_TAPS, 15, taps per band (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  DATA_W  signed input sample.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  DATA_W  signed equalized sample.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  1  0 = coefficient, 1 = gain.
- cfg_band  in  clog2(NUM_BANDS)  band index.
- cfg_tap  in  clog2(NUM_TAPS)  tap index (ignored for gain writes).
- cfg_data  in  max(COEF_W,GAIN_W)  write data; gain uses the low GAIN_W bits.
- cfg_busy  out  1  high when state != IDLE; config writes are dropped while high.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, in_ready=1, out_valid=0, out_data=0, cfg_busy=0, delay line=0, all coefficients=0, all gains=1<<GAIN_FRAC. Reset mid-computation abandons the sample with no output.
- FSM:
  - IDLE: in_valid&in_ready shifts in_data into delay line d[0] (d[k]<=d[k-1]), clears the accumulators, then goes to MAC with band=0, tap=0.
  - MAC: one cycle per tap: acc += d[tap]*coef[band][tap]. After NUM_TAPS cycles goes to BAND.
  - BAND: one cycle. b = sat_DATA_W(acc >>> (COEF_W-1)); sum += b*gain[band]; acc cleared. If band==NUM_BANDS-1 go to FINAL, else band++ and go to MAC.
  - FINAL: one cycle. out_data <= sat_DATA_W(sum >>> GAIN_FRAC); out_valid <= 1; go to OUT.
  - OUT: hold out_data/out_valid until out_ready. On out_valid&out_ready: out_valid <= 0, go to IDLE. in_ready is high the next cycle.
- in_ready = (state==IDLE). out_valid is never dropped without a handshake.
- Latency: out_valid rises NUM_BANDS*(NUM_TAPS+1)+1 cycles after the input handshake edge (129 for defaults).
- Arithmetic:
  - Accumulator width: DATA_W+COEF_W+clog2(NUM_TAPS).
  - Sum width: DATA_W+GAIN_W+clog2(NUM_BANDS).
  - Shifts are arithmetic (floor, truncation, no rounding).
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Config:
  - Write applies on the clk edge when cfg_we=1 and state==IDLE.
  - Out-of-range cfg_band/cfg_tap writes are ignored.
  - Same-cycle cfg write and input accept: the write takes effect first, so the new value is used for that sample.

Decomposition:
- Package eq_pkg: state enum (IDLE, MAC, BAND, FINAL, OUT), CFG_COEF/CFG_GAIN constants, saturate function, acc/sum width helper functions.
- Sub-module eq_mac: signed multiplier plus accumulator with clear/enable.
- Coefficient/gain storage and FSM stay in eq_nband_tdm.

Test Plan:
- Impulse: coef[0][0]=16384, coef[0][2]=-8192, other coefs 0, gains unity. Inputs 20000,0,0 give outputs 10000, 0, -5000, each 129 cycles after accept.
- Positive saturation: coef[0][0]=coef[1][0]=32767, gains 16. x=30000 gives each band 29999, sum 59998, out 32767. x=-30000 gives -32768.
- Gain scaling: setup as impulse test with gain[0]=8. x=20000 gives 5000; gain[0]=-16 gives -10000.
- Backpressure: hold out_ready=0 for 50 cycles after out_valid. out_data stays stable and in_ready stays 0. Releasing gives a single handshake, then in_ready=1 on the next cycle.
- Config while busy: write coef[0][0]=0 during MAC; the write is dropped and the impulse result stays 10000. The same write in IDLE then gives 0.
- Reset mid-operation: rst_n=0 during BAND of band 3. Next cycle out_valid=0, in_ready=1, gains unity, coefs 0. A following input yields output 0.
